// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit:
// FSM state enum, opcode values, datapath mux selects and the control bundle.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEM_ADR = 4'd2,
      S_MEM_RD  = 4'd3,
      S_MEM_WB  = 4'd4,
      S_MEM_WR  = 4'd5,
      S_EXEC_R  = 4'd6,
      S_EXEC_I  = 4'd7,
      S_ALU_WB  = 4'd8,
      S_BRANCH  = 4'd9,
      S_JAL     = 4'd10,
      S_JALR    = 4'd11,
      S_TRAP    = 4'd12
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [1:0] SRCA_PC     = 2'b00;
   localparam logic [1:0] SRCA_OLDPC  = 2'b01;
   localparam logic [1:0] SRCA_RS1    = 2'b10;
   localparam logic [1:0] SRCB_RS2    = 2'b00;
   localparam logic [1:0] SRCB_IMM    = 2'b01;
   localparam logic [1:0] SRCB_FOUR   = 2'b10;
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] RES_ALUOUT  = 2'b00;
   localparam logic [1:0] RES_MEMDATA = 2'b01;
   localparam logic [1:0] RES_ALU     = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       adr_src;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] result_src;
      logic       trap;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

   function automatic logic is_mem_op(input logic [6:0] opc);
      return (opc == OP_LOAD) || (opc == OP_STORE);
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Unified memory port handshake between the control unit (master) and memory (slave).
interface multicycle_control_fsm_if;
   logic mem_req;
   logic mem_we;
   logic adr_src;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output adr_src, input mem_ready);
   modport slave  (input mem_req, input mem_we, input adr_src, output mem_ready);
endinterface

// File: rtl/mc_branch_eval.sv
// Conditional-branch resolver: decides take/not-take from funct3 and the ALU
// zero flag, and flags funct3 encodings this core does not implement.
module mc_branch_eval
   import mc_ctrl_pkg::*;
(
   input  logic [2:0] i_funct3,
   input  logic       i_zero,
   output logic       o_take,
   output logic       o_legal
);

   // beq/bne resolution; anything else never takes and is reported illegal
   always_comb begin
      o_take  = 1'b0;
      o_legal = 1'b0;
      case (i_funct3)
         F3_BEQ: begin
            o_take  = i_zero;
            o_legal = 1'b1;
         end
         F3_BNE: begin
            o_take  = ~i_zero;
            o_legal = 1'b1;
         end
         default: begin
            o_take  = 1'b0;
            o_legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM driving a shared PC/IR/regfile/ALU/memory datapath.
// Define MC_ILLEGAL_TRAP_EN to halt in TRAP on illegal encodings instead of skipping them.
module multicycle_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int OP_W      = 7,
   parameter int INSTRET_W = 32
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [OP_W-1:0]           op,
   input  logic [2:0]                funct3,
   input  logic                      zero,
   multicycle_control_fsm_if.master  mem,
   output logic                      ir_write,
   output logic                      pc_write,
   output logic                      reg_write,
   output logic [1:0]                alu_src_a,
   output logic [1:0]                alu_src_b,
   output logic [1:0]                alu_op,
   output logic [1:0]                result_src,
   output logic [INSTRET_W-1:0]      instret,
   output logic                      trap
);

`ifdef MC_ILLEGAL_TRAP_EN
   localparam bit     TRAP_EN      = 1'b1;
   localparam state_e ILLEGAL_NEXT = S_TRAP;
`else
   localparam bit     TRAP_EN      = 1'b0;
   localparam state_e ILLEGAL_NEXT = S_FETCH;
`endif

   localparam logic [OP_W-1:0] LP_LOAD   = OP_W'(OP_LOAD);
   localparam logic [OP_W-1:0] LP_STORE  = OP_W'(OP_STORE);
   localparam logic [OP_W-1:0] LP_RTYPE  = OP_W'(OP_RTYPE);
   localparam logic [OP_W-1:0] LP_ITYPE  = OP_W'(OP_ITYPE);
   localparam logic [OP_W-1:0] LP_BRANCH = OP_W'(OP_BRANCH);
   localparam logic [OP_W-1:0] LP_JAL    = OP_W'(OP_JAL);
   localparam logic [OP_W-1:0] LP_JALR   = OP_W'(OP_JALR);

   state_e               r_state;
   state_e               w_next;
   logic [INSTRET_W-1:0] r_instret;
   ctrl_t                w_ctrl;
   ctrl_t                w_out;
   logic                 w_retire;
   logic                 w_take;
   logic                 w_br_legal;

   mc_branch_eval u_branch_eval (
      .i_funct3 (funct3),
      .i_zero   (zero),
      .o_take   (w_take),
      .o_legal  (w_br_legal)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         r_instret <= '0;
      end else if (w_retire) begin
         r_instret <= r_instret + INSTRET_W'(1);
      end else begin
         r_instret <= r_instret;
      end
   end

   // Next-state and per-state Moore outputs (fetch/branch enables qualified by inputs)
   always_comb begin
      w_next   = r_state;
      w_ctrl   = CTRL_IDLE;
      w_retire = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_ctrl.mem_req    = 1'b1;
            w_ctrl.alu_src_a  = SRCA_PC;
            w_ctrl.alu_src_b  = SRCB_FOUR;
            w_ctrl.alu_op     = ALUOP_ADD;
            w_ctrl.result_src = RES_ALU;
            if (mem.mem_ready) begin
               w_ctrl.ir_write = 1'b1;
               w_ctrl.pc_write = 1'b1;
               w_next          = S_DECODE;
            end else begin
               w_next = S_FETCH;
            end
         end
         S_DECODE: begin
            w_ctrl.alu_src_a = SRCA_OLDPC;
            w_ctrl.alu_src_b = SRCB_IMM;
            case (op)
               LP_LOAD, LP_STORE: w_next = S_MEM_ADR;
               LP_RTYPE:          w_next = S_EXEC_R;
               LP_ITYPE:          w_next = S_EXEC_I;
               LP_BRANCH:         w_next = S_BRANCH;
               LP_JAL:            w_next = S_JAL;
               LP_JALR:           w_next = S_JALR;
               default:           w_next = ILLEGAL_NEXT;
            endcase
         end
         S_MEM_ADR: begin
            w_ctrl.alu_src_a = SRCA_RS1;
            w_ctrl.alu_src_b = SRCB_IMM;
            if (op == LP_LOAD) begin
               w_next = S_MEM_RD;
            end else if (op == LP_STORE) begin
               w_next = S_MEM_WR;
            end else begin
               w_next = ILLEGAL_NEXT;
            end
         end
         S_MEM_RD: begin
            w_ctrl.mem_req = 1'b1;
            w_ctrl.adr_src = 1'b1;
            if (mem.mem_ready) begin
               w_next = S_MEM_WB;
            end else begin
               w_next = S_MEM_RD;
            end
         end
         S_MEM_WB: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.result_src = RES_MEMDATA;
            w_retire          = 1'b1;
            w_next            = S_FETCH;
         end
         S_MEM_WR: begin
            w_ctrl.mem_req = 1'b1;
            w_ctrl.mem_we  = 1'b1;
            w_ctrl.adr_src = 1'b1;
            if (mem.mem_ready) begin
               w_retire = 1'b1;
               w_next   = S_FETCH;
            end else begin
               w_next = S_MEM_WR;
            end
         end
         S_EXEC_R, S_EXEC_I: begin
            w_ctrl.alu_src_a = SRCA_RS1;
            w_ctrl.alu_src_b = (r_state == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
            w_ctrl.alu_op    = ALUOP_FUNCT;
            w_next           = S_ALU_WB;
         end
         S_ALU_WB: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.result_src = RES_ALUOUT;
            w_retire          = 1'b1;
            w_next            = S_FETCH;
         end
         S_BRANCH: begin
            w_ctrl.alu_src_a  = SRCA_RS1;
            w_ctrl.alu_src_b  = SRCB_RS2;
            w_ctrl.alu_op     = ALUOP_SUB;
            w_ctrl.result_src = RES_ALUOUT;
            w_ctrl.pc_write   = w_take;
            // Unsupported funct3 halts when trapping, otherwise retires as not-taken
            if (w_br_legal || !TRAP_EN) begin
               w_retire = 1'b1;
               w_next   = S_FETCH;
            end else begin
               w_next = ILLEGAL_NEXT;
            end
         end
         S_JAL: begin
            w_ctrl.alu_src_a  = SRCA_OLDPC;
            w_ctrl.alu_src_b  = SRCB_FOUR;
            w_ctrl.result_src = RES_ALUOUT;
            w_ctrl.pc_write   = 1'b1;
            w_next            = S_ALU_WB;
         end
         S_JALR: begin
            w_ctrl.alu_src_a  = SRCA_RS1;
            w_ctrl.alu_src_b  = SRCB_IMM;
            w_ctrl.alu_op     = ALUOP_ADD;
            w_ctrl.result_src = RES_ALU;
            w_ctrl.pc_write   = 1'b1;
            w_next            = S_ALU_WB;
         end
         S_TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
            w_ctrl.trap = 1'b1;
            w_next      = S_TRAP;
`else
            w_next      = S_FETCH;
`endif
         end
         default: begin
            w_next = S_FETCH;
         end
      endcase
   end

   // Reset forces every output low in the same cycle, even mid memory wait
   always_comb begin
      if (rst) begin
         w_out = CTRL_IDLE;
      end else begin
         w_out = w_ctrl;
      end
   end

   assign mem.mem_req = w_out.mem_req;
   assign mem.mem_we  = w_out.mem_we;
   assign mem.adr_src = w_out.adr_src;
   assign ir_write    = w_out.ir_write;
   assign pc_write    = w_out.pc_write;
   assign reg_write   = w_out.reg_write;
   assign alu_src_a   = w_out.alu_src_a;
   assign alu_src_b   = w_out.alu_src_b;
   assign alu_op      = w_out.alu_op;
   assign result_src  = w_out.result_src;
   assign trap        = w_out.trap;
   assign instret     = rst ? '0 : r_instret;

endmodule
